// File: rtl/color_slot_scheduler.sv
// Round-robin colour-profile scheduler for the red_frame tracker.
// A shadow bank holds up to four Cr/Cb threshold profiles. One profile is applied per video
// frame, and it is swapped only during vertical blanking. The tracker's line/column result
// for each frame is captured into a per-slot result bank.
module color_slot_scheduler #(
  parameter int unsigned NUM_SLOTS     = 4,
  parameter int unsigned CAPTURE_DELAY = 2
) (
  input  logic                 iVgaClk,
  input  logic                 reset,
  input  logic                 iVgaVRequest,
  input  logic [8:0]           iTrackLine,
  input  logic [9:0]           iTrackCol,
  input  logic [NUM_SLOTS-1:0] iSlotEnable,
  input  logic                 iCfgWrite,
  input  logic [1:0]           iCfgSlot,
  input  logic [7:0]           iCfgCrLow,
  input  logic [7:0]           iCfgCrHigh,
  input  logic [7:0]           iCfgCbLow,
  input  logic [7:0]           iCfgCbHigh,
  input  logic                 iCfgFilterOn,
  output logic [7:0]           oCrLow,
  output logic [7:0]           oCrHigh,
  output logic [7:0]           oCbLow,
  output logic [7:0]           oCbHigh,
  output logic                 oFilterOn,
  output logic [1:0]           oActiveSlot,
  output logic                 oResultWrite,
  output logic [1:0]           oResultSlot,
  input  logic [1:0]           iRdSlot,
  output logic [8:0]           oRdLine,
  output logic [9:0]           oRdCol,
  output logic                 oRdValid
);

  // Default profile and default result
  localparam logic [7:0] RstCrLow   = 8'd150;
  localparam logic [7:0] RstCrHigh  = 8'd255;
  localparam logic [7:0] RstCbLow   = 8'd0;
  localparam logic [7:0] RstCbHigh  = 8'd120;
  localparam logic       RstFilter  = 1'b1;
  localparam logic [8:0] RstLine    = 9'd240;
  localparam logic [9:0] RstCol     = 10'd320;

  localparam logic [2:0] NumSlots3  = 3'(NUM_SLOTS);
  localparam logic [3:0] SettleLast = 4'(CAPTURE_DELAY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StSettle,
    StCapture
  } stateT;

  stateT       state, stateNext;
  logic [3:0]  cnt, cntNext;

  logic        vPrev;
  logic        vRise;
  logic        vFall;

  logic [3:0]  enMask;
  logic        activeEnabled;
  logic        cfgWriteOk;

  // Shadow profile bank
  logic [7:0]  shCrLow  [4];
  logic [7:0]  shCrHigh [4];
  logic [7:0]  shCbLow  [4];
  logic [7:0]  shCbHigh [4];
  logic [3:0]  shFilter;

  // Per-slot result bank
  logic [8:0]  resLine [4];
  logic [9:0]  resCol  [4];
  logic [3:0]  resValid;

  logic        lowestFound;
  logic [1:0]  lowestSlot;
  logic        nextFound;
  logic [1:0]  nextSlot;
  logic [2:0]  scanIdx;

  logic        loadEn;
  logic [1:0]  loadSlot;
  logic        capWrite;

  logic [7:0]  ldCrLow;
  logic [7:0]  ldCrHigh;
  logic [7:0]  ldCbLow;
  logic [7:0]  ldCbHigh;
  logic        ldFilter;

  assign vRise = iVgaVRequest & ~vPrev;
  assign vFall = ~iVgaVRequest & vPrev;

  // Unimplemented slots read as disabled
  assign enMask        = 4'(iSlotEnable);
  assign activeEnabled = enMask[oActiveSlot];
  assign cfgWriteOk    = iCfgWrite && ({1'b0, iCfgSlot} < NumSlots3);

  assign lowestFound = |enMask;
  assign lowestSlot  = enMask[0] ? 2'd0 :
                       enMask[1] ? 2'd1 :
                       enMask[2] ? 2'd2 : 2'd3;

  // First enabled slot after the active one, wrapping; may land on the active slot itself
  always_comb begin
    nextFound = 1'b0;
    nextSlot  = oActiveSlot;
    scanIdx   = 3'd0;
    // Scan from the farthest offset down so the nearest enabled slot wins
    for (int k = int'(NUM_SLOTS); k >= 1; k--) begin
      scanIdx = {1'b0, oActiveSlot} + 3'(k);
      if (scanIdx >= NumSlots3) begin
        scanIdx = scanIdx - NumSlots3;
      end
      if (enMask[scanIdx[1:0]]) begin
        nextFound = 1'b1;
        nextSlot  = scanIdx[1:0];
      end
    end
  end

  // Next-state logic; loads only happen entering ARM from IDLE or in CAPTURE
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    loadEn    = 1'b0;
    loadSlot  = oActiveSlot;
    capWrite  = 1'b0;
    case (state)
      StIdle: begin
        if (lowestFound) begin
          loadEn    = 1'b1;
          loadSlot  = lowestSlot;
          stateNext = StArm;
        end
      end
      StArm: begin
        // Only a rise seen here starts a frame, so a partial frame is never captured
        if (vRise) begin
          stateNext = StRun;
        end
      end
      StRun: begin
        if (vFall) begin
          stateNext = StSettle;
          cntNext   = 4'd0;
        end
      end
      StSettle: begin
        cntNext = cnt + 4'd1;
        if (cnt == SettleLast) begin
          stateNext = StCapture;
        end
      end
      StCapture: begin
        capWrite = activeEnabled;
        if (nextFound) begin
          loadEn    = 1'b1;
          loadSlot  = nextSlot;
          stateNext = StArm;
        end else begin
          stateNext = StIdle;
        end
      end
      default: begin
        stateNext = StIdle;
      end
    endcase
  end

  // Profile to load; a same-cycle write to the loaded slot passes straight through
  always_comb begin
    if (cfgWriteOk && (iCfgSlot == loadSlot)) begin
      ldCrLow  = iCfgCrLow;
      ldCrHigh = iCfgCrHigh;
      ldCbLow  = iCfgCbLow;
      ldCbHigh = iCfgCbHigh;
      ldFilter = iCfgFilterOn;
    end else begin
      ldCrLow  = shCrLow[loadSlot];
      ldCrHigh = shCrHigh[loadSlot];
      ldCbLow  = shCbLow[loadSlot];
      ldCbHigh = shCbHigh[loadSlot];
      ldFilter = shFilter[loadSlot];
    end
  end

  // FSM state, settle counter and VRequest edge-detect register
  always_ff @(posedge iVgaClk) begin
    if (!reset) begin
      state <= StIdle;
      cnt   <= 4'd0;
      vPrev <= 1'b1;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      vPrev <= iVgaVRequest;
    end
  end

  // Shadow bank writes from the host
  always_ff @(posedge iVgaClk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        shCrLow[i]  <= RstCrLow;
        shCrHigh[i] <= RstCrHigh;
        shCbLow[i]  <= RstCbLow;
        shCbHigh[i] <= RstCbHigh;
      end
      shFilter <= {4{RstFilter}};
    end else if (cfgWriteOk) begin
      shCrLow[iCfgSlot]  <= iCfgCrLow;
      shCrHigh[iCfgSlot] <= iCfgCrHigh;
      shCbLow[iCfgSlot]  <= iCfgCbLow;
      shCbHigh[iCfgSlot] <= iCfgCbHigh;
      shFilter[iCfgSlot] <= iCfgFilterOn;
    end
  end

  // Thresholds driven to the tracker change only on a load
  always_ff @(posedge iVgaClk) begin
    if (!reset) begin
      oCrLow      <= RstCrLow;
      oCrHigh     <= RstCrHigh;
      oCbLow      <= RstCbLow;
      oCbHigh     <= RstCbHigh;
      oFilterOn   <= RstFilter;
      oActiveSlot <= 2'd0;
    end else if (loadEn) begin
      oCrLow      <= ldCrLow;
      oCrHigh     <= ldCrHigh;
      oCbLow      <= ldCbLow;
      oCbHigh     <= ldCbHigh;
      oFilterOn   <= ldFilter;
      oActiveSlot <= loadSlot;
    end
  end

  // Result capture; a profile write invalidates that slot's stored result
  always_ff @(posedge iVgaClk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        resLine[i] <= RstLine;
        resCol[i]  <= RstCol;
      end
      resValid     <= 4'd0;
      oResultWrite <= 1'b0;
      oResultSlot  <= 2'd0;
    end else begin
      oResultWrite <= capWrite;
      if (capWrite) begin
        resLine[oActiveSlot]  <= iTrackLine;
        resCol[oActiveSlot]   <= iTrackCol;
        resValid[oActiveSlot] <= 1'b1;
        oResultSlot           <= oActiveSlot;
      end
      if (cfgWriteOk) begin
        resValid[iCfgSlot] <= 1'b0;
      end
    end
  end

  // Combinational result read port
  always_comb begin
    if ({1'b0, iRdSlot} < NumSlots3) begin
      oRdLine  = resLine[iRdSlot];
      oRdCol   = resCol[iRdSlot];
      oRdValid = resValid[iRdSlot];
    end else begin
      oRdLine  = RstLine;
      oRdCol   = RstCol;
      oRdValid = 1'b0;
    end
  end

endmodule
